// File: rtl/uart_rx_frontend_pkg.sv
// Shared types and helpers for the UART receive front end.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = (clk_hz + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_frontend_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1, tick on the wrap count; restart re-phases it to 0.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: pin synchroniser, oversampled 8N1 deframer and one-entry output holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with the io_parity_err pulse.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_rx,
  output logic [UART_DATA_W-1:0] io_data,
  output logic                   io_valid,
  input  logic                   io_ready,
  output logic                   io_framing_err,
  output logic                   io_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                   io_parity_err,
`endif
  output rx_state_t              dbg_state
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);

  // Output handshake: a byte transfers on a rising edge where io_valid and io_ready are both 1;
  // io_data is held constant while io_valid=1 and io_ready=0.

  rx_state_t              state, state_nxt;
  logic                   sync1, rxs, tick, mid, restart, deliver, frame_err;
  logic [SW-1:0]          scnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                   par_err, par_bad;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= io_rx;
      rxs   <= sync1;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign mid = tick && (scnt == MID_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rxs) state_nxt = START;
      START:  if (mid) state_nxt = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (mid && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY: if (mid) state_nxt = STOP;
`else
      DATA:   if (mid && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:   if (mid) state_nxt = rxs ? IDLE : BREAK;
      BREAK:  if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    restart   = 1'b0;
    deliver   = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err   = 1'b0;
`endif
    case (state)
      IDLE: restart = !rxs;
      STOP: begin
        deliver   = mid && rxs;
        frame_err = mid && !rxs;
`ifdef UART_RX_PARITY_EN
        if (par_bad) deliver = 1'b0;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: par_err = mid && (rxs != ^shreg);
`endif
      default: ;
    endcase
  end

  // Sample counter is parked at 0 in IDLE so the first mid-bit lands half a bit after the start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE)  scnt <= '0;
      else if (tick)      scnt <= (scnt == LAST_CNT) ? '0 : scnt + SW'(1);
      if (mid && state == START) bit_idx <= '0;
      if (mid && state == DATA) begin
        shreg   <= {rxs, shreg[UART_DATA_W-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_bad       <= 1'b0;
      io_parity_err <= 1'b0;
    end else begin
      io_parity_err <= par_err;
      if (mid && state == START) par_bad <= 1'b0;
      else if (par_err)          par_bad <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_data        <= '0;
      io_valid       <= 1'b0;
      io_overrun     <= 1'b0;
      io_framing_err <= 1'b0;
    end else begin
      io_overrun     <= deliver && io_valid && !io_ready;
      io_framing_err <= frame_err;
      if (deliver) begin
        if (!io_valid || io_ready) begin
          io_data  <= shreg;
          io_valid <= 1'b1;
        end
      end else if (io_valid && io_ready) begin
        io_valid <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: frame-level reference model of expected deliveries/errors and a byte scoreboard.
module tb_uart_rx_frontend;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;
  // Decision cycle of the stop bit, counted from the cycle the start bit is driven:
  // 2 sync flops + 1 to leave IDLE + half a bit to the mid-sample + 9 further bits.
  localparam int DELIV_OFS = 2 + 1 + (BIT_CLKS / 2 - 1) + 9 * BIT_CLKS;
  localparam int K_DLV = 0, K_FERR = 1, K_PERR = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clock, reset, io_rx, io_ready;
  logic [7:0] io_data;
  logic       io_valid, io_framing_err, io_overrun;
  rx_state_t  dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       io_parity_err;
`endif

  uart_rx_frontend #(.CLK_HZ(6_400_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_rx          (io_rx),
    .io_data        (io_data),
    .io_valid       (io_valid),
    .io_ready       (io_ready),
    .io_framing_err (io_framing_err),
    .io_overrun     (io_overrun),
`ifdef UART_RX_PARITY_EN
    .io_parity_err  (io_parity_err),
`endif
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  ev_t        ev_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_low, input bit par_wrong,
                            input int abort_at);
    int c;
    c = cyc;
    io_rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        io_rx = 1'b1;
        #1;
        check("reset_async_valid", 32'(io_valid), 32'd0);
        check("reset_async_data", 32'(io_data), 32'd0);
        step(3);
        reset = 1'b0;
        return;
      end
      io_rx = b[i];
      step(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    if (par_wrong) ev_q.push_back('{c + DELIV_OFS, K_PERR, b});
    if (stop_low)       ev_q.push_back('{c + DELIV_OFS + BIT_CLKS, K_FERR, b});
    else if (!par_wrong) ev_q.push_back('{c + DELIV_OFS + BIT_CLKS, K_DLV, b});
    io_rx = (^b) ^ par_wrong;
    step(BIT_CLKS);
`else
    ev_q.push_back('{c + DELIV_OFS, stop_low ? K_FERR : K_DLV, b});
`endif
    io_rx = !stop_low;
    step(BIT_CLKS);
  endtask

  // reference model + scoreboard, evaluated mid-cycle
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       n_valid, dv, df, dp, prev_valid = 1'b0;
  logic [7:0] n_data, db, got;
  int         n_rise = 0, n_ovr = 0, n_ferr = 0, n_perr = 0, last_rise_cyc = 0;
  logic [7:0] last_rise_data = 8'h00;
  ev_t        e;

  always @(negedge clock) begin
    if (reset) begin
      check("reset_valid", 32'(io_valid), 32'd0);
      check("reset_data", 32'(io_data), 32'd0);
      check("reset_ovr", 32'(io_overrun), 32'd0);
      check("reset_ferr", 32'(io_framing_err), 32'd0);
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      prev_valid = 1'b0;
      exp_q.delete();
      ev_q.delete();
    end else begin
      check("valid", 32'(io_valid), 32'(m_valid));
      if (m_valid) check("data", 32'(io_data), 32'(m_data));
      check("overrun", 32'(io_overrun), 32'(m_ovr));
      check("framing_err", 32'(io_framing_err), 32'(m_ferr));
`ifdef UART_RX_PARITY_EN
      check("parity_err", 32'(io_parity_err), 32'(m_perr));
      if (io_parity_err) n_perr++;
`endif
      if (io_overrun) n_ovr++;
      if (io_framing_err) n_ferr++;
      if (io_valid && !prev_valid) begin
        n_rise++;
        last_rise_cyc = cyc;
        last_rise_data = io_data;
      end
      prev_valid = io_valid;
      if (io_valid && io_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", 32'(io_data), 32'hFFFF_FFFF);
        end else begin
          got = exp_q.pop_front();
          check("sb_byte", 32'(io_data), 32'(got));
        end
      end
      dv = 1'b0; df = 1'b0; dp = 1'b0; db = 8'h00;
      while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
        e = ev_q.pop_front();
        check("event_on_time", 32'(e.cyc), 32'(cyc));
        if (e.kind == K_DLV) begin dv = 1'b1; db = e.data; end
        else if (e.kind == K_FERR) df = 1'b1;
        else dp = 1'b1;
      end
      n_valid = m_valid;
      n_data  = m_data;
      if (m_valid && io_ready) n_valid = 1'b0;
      m_ovr = 1'b0;
      if (dv) begin
        if (m_valid && !io_ready) m_ovr = 1'b1;
        else begin
          n_valid = 1'b1;
          n_data  = db;
          exp_q.push_back(db);
        end
      end
      m_valid = n_valid;
      m_data  = n_data;
      m_ferr  = df;
      m_perr  = dp;
    end
  end

  // stimulus
  int  c1, r0, o0, f0;
  bit  done;
  logic [7:0] rb;

  initial begin
    reset = 1'b1; io_rx = 1'b1; io_ready = 1'b0;
    step(5);
    reset = 1'b0;
    step(20);

    // 1: single byte, consumer ready
    io_ready = 1'b1;
    c1 = cyc; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, 0, 0, -1);
    step(10);
    check("t1_latency", 32'(last_rise_cyc - c1), 32'd611);
    check("t1_data", 32'(last_rise_data), 32'h55);
    check("t1_no_err", 32'(n_ferr - f0 + n_ovr - o0), 32'd0);

    // 2: overrun while holding register is full
    io_ready = 1'b0; o0 = n_ovr;
    send_frame(8'hA3, 0, 0, -1);
    send_frame(8'h3C, 0, 0, -1);
    step(5);
    check("t2_hold_data", 32'(io_data), 32'hA3);
    check("t2_hold_valid", 32'(io_valid), 32'd1);
    check("t2_ovr_once", 32'(n_ovr - o0), 32'd1);
    io_ready = 1'b1;
    step(2);
    check("t2_drained", 32'(io_valid), 32'd0);

    // 3: ready raised exactly in the delivery cycle of the second byte
    io_ready = 1'b0;
    send_frame(8'h11, 0, 0, -1);
    o0 = n_ovr;
    fork
      send_frame(8'h22, 0, 0, -1);
      begin
        step(DELIV_OFS);
        io_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("t3_data", 32'(io_data), 32'h22);
        check("t3_valid", 32'(io_valid), 32'd1);
        check("t3_no_ovr", 32'(n_ovr - o0), 32'd0);
      end
    join
    step(10);

    // 4: framing error followed by a held-low break, then a clean frame
    f0 = n_ferr; r0 = n_rise;
    send_frame(8'hF0, 1, 0, -1);
    step(20 * BIT_CLKS);
    io_rx = 1'b1;
    step(100);
    send_frame(8'h0F, 0, 0, -1);
    step(10);
    check("t4_ferr_once", 32'(n_ferr - f0), 32'd1);
    check("t4_one_byte", 32'(n_rise - r0), 32'd1);
    check("t4_data", 32'(last_rise_data), 32'h0F);

    // 5: glitch is a false start; reset mid-frame then recover
    r0 = n_rise; f0 = n_ferr;
    io_rx = 1'b0;
    step(20);
    io_rx = 1'b1;
    step(200);
    check("t5_glitch_no_byte", 32'(n_rise - r0), 32'd0);
    check("t5_glitch_no_err", 32'(n_ferr - f0), 32'd0);
    io_ready = 1'b0;
    send_frame(8'h5A, 0, 0, -1);
    send_frame(8'hC3, 0, 0, 4);
    step(50);
    io_ready = 1'b1;
    send_frame(8'h7E, 0, 0, -1);
    step(10);
    check("t5_after_reset", 32'(last_rise_data), 32'h7E);

`ifdef UART_RX_PARITY_EN
    // 6: wrong then correct parity
    r0 = n_rise; o0 = n_perr;
    send_frame(8'h07, 0, 1, -1);
    step(10);
    check("t6_perr", 32'(n_perr - o0), 32'd1);
    check("t6_no_byte", 32'(n_rise - r0), 32'd0);
    send_frame(8'h07, 0, 0, -1);
    step(10);
    check("t6_data", 32'(last_rise_data), 32'h07);
`endif

    // random traffic with a randomly stalling consumer
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 14; k++) begin
          rb = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) begin
            send_frame(rb, 1, 0, -1);
            step(BIT_CLKS * $urandom_range(1, 3));
            io_rx = 1'b1;
            step(20);
          end else begin
            send_frame(rb, 0, 0, -1);
          end
          step($urandom_range(0, 100));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          io_ready = 1'($urandom_range(0, 1));
          step(1);
        end
      end
    join
    io_ready = 1'b1;
    step(50);
    check("end_sb_empty", 32'(exp_q.size()), 32'd0);
    check("end_events_empty", 32'(ev_q.size()), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
